nn_sequencer: RTL and testbench
===============================

NN_SEQUENCER -- requirements
Module: nn_sequencer

Interface
REQ-001 SHALL have parameter NumWords, default 49: count of 32-bit weight words shifted per run (>=1).
REQ-002 SHALL have parameter NumOutputLayer, default 4: count of output neurons (lanes).
REQ-003 SHALL have parameter DataWidth, default 8: width of each output lane.
REQ-004 SHALL have parameter TimeoutCycles, default 1024: watchdog limit, used only with the REQ-029 macro.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start_i, input, 1: begin a run; sampled only in IDLE.
REQ-008 SHALL have ports wt_valid_i (input, 1), wt_data_i (input, 32) and wt_ready_o (output, 1): the weight source stream.
REQ-009 SHALL have ports shift_o (output, 1) and weights_o (output, 32): drive to the datapath shift chain.
REQ-010 SHALL have ports infer_req_o (output, 1) and infer_ack_i (input, 1): the inference request handshake.
REQ-011 SHALL have ports nn_req_i (input, NumOutputLayer) and nn_ack_o (output, NumOutputLayer): per-lane output handshake.
REQ-012 SHALL have port nn_output_i, input, DataWidth*NumOutputLayer: datapath outputs; lane k is bits [k*DataWidth +: DataWidth].
REQ-013 SHALL have ports result_o (output, DataWidth*NumOutputLayer) and result_valid_o (output, 1): captured results.
REQ-014 SHALL have ports busy_o (output, 1), done_o (output, 1) and error_o (output, 1): status.

Function
REQ-015 SHALL implement the states IDLE, LOAD, SETTLE, INFER, COLLECT and DONE; busy_o SHALL be 1 in every state except IDLE.
REQ-016 In IDLE, start_i=1 SHALL move to LOAD next cycle and clear the word counter and the collected mask; start_i outside IDLE SHALL be ignored.
REQ-017 In LOAD, wt_ready_o SHALL be 1; each cycle with wt_valid_i&wt_ready_o SHALL accept one word and increment the counter; wt_ready_o SHALL be 0 in all other states.
REQ-018 Each accepted word SHALL appear on weights_o with shift_o=1 for exactly one cycle, one cycle after acceptance; shift_o SHALL be 0 otherwise, and weights_o SHALL hold its last value.
REQ-019 Acceptance of word NumWords-1 (0-based) SHALL move to SETTLE; no further words SHALL be accepted that run; wt_valid_i gaps SHALL only stall.
REQ-020 SETTLE SHALL last exactly one cycle, then move to INFER.
REQ-021 In INFER, infer_req_o SHALL be 1 and held until infer_ack_i=1 is sampled; that edge SHALL clear infer_req_o and move to COLLECT.
REQ-022 In COLLECT, for each lane k with nn_req_i[k]=1 and collected[k]=0, the block SHALL pulse nn_ack_o[k] for one cycle, capture lane k of nn_output_i into result_o lane k, and set collected[k]; multiple lanes in the same cycle SHALL all be served.
REQ-023 A lane already collected SHALL never be re-acked or re-captured in the same run.
REQ-024 When all collected bits are 1, the block SHALL move to DONE; in DONE, result_valid_o and done_o SHALL be 1 for exactly one cycle, then return to IDLE.
REQ-025 result_o SHALL hold its value until lanes are overwritten in the next run.

Reset
REQ-026 reset_i=1 SHALL immediately force IDLE, with the counter, collected mask, shift_o, weights_o, infer_req_o, nn_ack_o, result_o, result_valid_o, done_o, error_o and busy_o all 0, and wt_ready_o 0.
REQ-027 Reset mid-run SHALL abandon the run; after release, the block SHALL idle until a new start_i.
REQ-028 Deassertion SHALL take effect on the next clk_i rising edge.

Configuration
REQ-029 With NN_SEQ_TIMEOUT_EN defined, a cycle counter SHALL run in INFER and COLLECT; reaching TimeoutCycles SHALL set error_o (sticky until the next accepted start_i), drop infer_req_o and nn_ack_o, and return to IDLE without result_valid_o.
REQ-030 Without NN_SEQ_TIMEOUT_EN, there SHALL be no watchdog, error_o SHALL be tied to 0, and INFER/COLLECT SHALL wait indefinitely.

Verification
REQ-031 NumWords=3: start, three back-to-back words 0x11,0x22,0x33 -> three consecutive shift_o pulses with weights_o 0x11,0x22,0x33, each one cycle after acceptance.
REQ-032 wt_valid_i toggled 1,0,0,1,1 -> exactly 3 shift_o pulses, gaps mirrored, then SETTLE for 1 cycle, then infer_req_o=1.
REQ-033 Delay infer_ack_i by 5 cycles -> infer_req_o high for 5 cycles then 0; lanes 2,0 req in one cycle, lanes 1,3 later with outputs 0xA0..0xA3 -> each nn_ack_o bit pulses once, result_o=0xA3A2A1A0, done_o and result_valid_o pulse once.
REQ-034 start_i asserted during LOAD, and nn_req_i[1] held high for 4 cycles -> no restart and only one ack on lane 1.
REQ-035 Assert reset_i mid-LOAD after 2 words -> all outputs 0 immediately; new start_i reloads the full NumWords.
REQ-036 With NN_SEQ_TIMEOUT_EN and TimeoutCycles=16, infer_ack_i never asserted -> error_o=1 after 16 cycles in INFER, IDLE, no result_valid_o; next start_i clears error_o.

Source files
------------

// File: rtl/nn_sequencer.sv
// Sequences one inference: shift NumWords weights, settle, request inference, collect per-lane results.
// Optional watchdog on INFER/COLLECT enabled by defining NN_SEQ_TIMEOUT_EN.
module nn_sequencer #(
   parameter int NumWords       = 49,
   parameter int NumOutputLayer = 4,
   parameter int DataWidth      = 8,
   parameter int TimeoutCycles  = 1024
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic                                start_i,
   input  logic                                wt_valid_i,
   input  logic [31:0]                         wt_data_i,
   output logic                                wt_ready_o,
   output logic                                shift_o,
   output logic [31:0]                         weights_o,
   output logic                                infer_req_o,
   input  logic                                infer_ack_i,
   input  logic [NumOutputLayer-1:0]           nn_req_i,
   output logic [NumOutputLayer-1:0]           nn_ack_o,
   input  logic [DataWidth*NumOutputLayer-1:0] nn_output_i,
   output logic [DataWidth*NumOutputLayer-1:0] result_o,
   output logic                                result_valid_o,
   output logic                                busy_o,
   output logic                                done_o,
   output logic                                error_o
);
   localparam int CntW = (NumWords > 1) ? $clog2(NumWords) : 1;
   localparam logic [CntW-1:0] LastWord = CntW'(NumWords - 1);
   localparam logic [NumOutputLayer-1:0] AllLanes = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_INFER, S_COLLECT, S_DONE
   } state_t;

   state_t                              state_q, state_d;
   logic [CntW-1:0]                     cnt_q, cnt_d;
   logic [NumOutputLayer-1:0]           coll_q, coll_d;
   logic [NumOutputLayer-1:0]           ack_q, ack_d;
   logic                                shift_q, shift_d;
   logic [31:0]                         weights_q, weights_d;
   logic [DataWidth*NumOutputLayer-1:0] result_q, result_d;
   logic [NumOutputLayer-1:0]           hit;
   logic                                accept;
   logic                                timeout;

   assign accept = (state_q == S_LOAD) && wt_valid_i;
   // Lanes requesting this cycle that have not yet been served in this run.
   assign hit    = (state_q == S_COLLECT) ? (nn_req_i & ~coll_q) : '0;

`ifdef NN_SEQ_TIMEOUT_EN
   localparam int TmoW = $clog2(TimeoutCycles + 1);
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            error_q, error_d;
   logic            in_wait;

   assign in_wait = (state_q == S_INFER) || (state_q == S_COLLECT);
   assign timeout = in_wait && (tmo_q == TmoW'(TimeoutCycles - 1));

   always_comb begin
      tmo_d   = (in_wait && !timeout) ? tmo_q + 1'b1 : '0;
      error_d = error_q;
      if ((state_q == S_IDLE) && start_i) begin
         error_d = 1'b0;
      end
      if (timeout) begin
         error_d = 1'b1;
      end
   end

   assign error_o = error_q;
`else
   assign timeout = 1'b0;
   assign error_o = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      coll_d    = coll_q;
      shift_d   = accept;
      weights_d = accept ? wt_data_i : weights_q;
      ack_d     = hit;
      result_d  = result_q;
      for (int k = 0; k < NumOutputLayer; k++) begin
         if (hit[k]) begin
            result_d[k*DataWidth +: DataWidth] = nn_output_i[k*DataWidth +: DataWidth];
         end
      end
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               coll_d  = '0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastWord) begin
                  state_d = S_SETTLE;
               end
            end
         end
         S_SETTLE: state_d = S_INFER;
         S_INFER: begin
            if (infer_ack_i) begin
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            coll_d = coll_q | hit;
            if ((coll_q | hit) == AllLanes) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Watchdog expiry abandons the run without acking or capturing anything.
      if (timeout) begin
         state_d  = S_IDLE;
         ack_d    = '0;
         coll_d   = coll_q;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         coll_q    <= '0;
         ack_q     <= '0;
         shift_q   <= 1'b0;
         weights_q <= '0;
         result_q  <= '0;
`ifdef NN_SEQ_TIMEOUT_EN
         tmo_q     <= '0;
         error_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         coll_q    <= coll_d;
         ack_q     <= ack_d;
         shift_q   <= shift_d;
         weights_q <= weights_d;
         result_q  <= result_d;
`ifdef NN_SEQ_TIMEOUT_EN
         tmo_q     <= tmo_d;
         error_q   <= error_d;
`endif
      end
   end

   assign wt_ready_o     = (state_q == S_LOAD);
   assign shift_o        = shift_q;
   assign weights_o      = weights_q;
   assign infer_req_o    = (state_q == S_INFER);
   assign nn_ack_o       = ack_q;
   assign result_o       = result_q;
   assign result_valid_o = (state_q == S_DONE);
   assign done_o         = (state_q == S_DONE);
   assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_nn_sequencer.sv
// Directed + randomized bench for nn_sequencer with a rule-level reference model.
module tb_nn_sequencer;
   localparam int NW  = 3;
   localparam int NL  = 4;
   localparam int DW  = 8;
   localparam int TMO = 16;

   logic             clk_i = 1'b0;
   logic             reset_i, start_i, wt_valid_i, infer_ack_i;
   logic [31:0]      wt_data_i;
   logic             wt_ready_o, shift_o, infer_req_o, result_valid_o, busy_o, done_o, error_o;
   logic [31:0]      weights_o;
   logic [NL-1:0]    nn_req_i, nn_ack_o;
   logic [NL*DW-1:0] nn_output_i, result_o;

   int               errors = 0;
   int               checks = 0;
   logic [31:0]      last_w = '0;
   logic [NL*DW-1:0] exp_res = '0;

   always #5 clk_i = ~clk_i;

   nn_sequencer #(
      .NumWords(NW), .NumOutputLayer(NL), .DataWidth(DW), .TimeoutCycles(TMO)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
      .wt_valid_i(wt_valid_i), .wt_data_i(wt_data_i), .wt_ready_o(wt_ready_o),
      .shift_o(shift_o), .weights_o(weights_o),
      .infer_req_o(infer_req_o), .infer_ack_i(infer_ack_i),
      .nn_req_i(nn_req_i), .nn_ack_o(nn_ack_o), .nn_output_i(nn_output_i),
      .result_o(result_o), .result_valid_o(result_valid_o),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_wt_ready"}, wt_ready_o, 0);
      chk({tag, "_shift"}, shift_o, 0);
      chk({tag, "_weights"}, weights_o, 0);
      chk({tag, "_infer_req"}, infer_req_o, 0);
      chk({tag, "_nn_ack"}, nn_ack_o, 0);
      chk({tag, "_result"}, result_o, 0);
      chk({tag, "_result_valid"}, result_valid_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_error"}, error_o, 0);
   endtask

   // mode 0: words 0x11,0x22,.. back to back; mode 1: valid pattern 1,0,0,1,1; mode 2: random.
   // Model: the first NW valid beats after start are accepted, each echoed one cycle later.
   task automatic load_run(input int mode, input bit hold_start);
      bit          pv [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int          acc = 0;
      int          cyc = 0;
      bit          v;
      logic [31:0] d;
      while (acc < NW && cyc < 64) begin
         v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc < 5) ? pv[cyc] : 1'b1) : 1'($urandom_range(0, 1));
         d = (mode == 0) ? 32'h11 * (acc + 1) : $urandom;
         wt_valid_i = v;
         wt_data_i  = d;
         start_i    = hold_start;
         chk("wt_ready_load", wt_ready_o, 1);
         if (v) begin
            acc++;
            last_w = d;
         end
         tick;
         chk("shift_pulse", shift_o, v);
         chk("weights_val", weights_o, last_w);
         cyc++;
      end
      chk("load_budget", acc, NW);
      // SETTLE: one more valid beat is offered and must be ignored.
      wt_valid_i = 1'b1;
      wt_data_i  = 32'hDEAD_BEEF;
      start_i    = 1'b0;
      chk("wt_ready_settle", wt_ready_o, 0);
      chk("infer_req_settle", infer_req_o, 0);
      chk("busy_settle", busy_o, 1);
      tick;
      wt_valid_i = 1'b0;
      chk("no_extra_shift", shift_o, 0);
      chk("weights_hold", weights_o, last_w);
      chk("infer_req_rise", infer_req_o, 1);
   endtask

   task automatic infer_run(input int dly);
      for (int i = 0; i < dly; i++) begin
         chk("infer_req_hold", infer_req_o, 1);
         chk("nn_ack_quiet", nn_ack_o, 0);
         infer_ack_i = (i == dly - 1);
         tick;
      end
      infer_ack_i = 1'b0;
      chk("infer_req_drop", infer_req_o, 0);
   endtask

   // Model: a lane is acked and captured the first time it requests in a run, never again.
   task automatic collect_run(input bit directed);
      logic [NL-1:0] tbl [7] = '{4'b0101, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
      logic [NL-1:0] collected = '0;
      logic [NL-1:0] req, exp_ack;
      int            cyc = 0;
      while (collected != '1 && cyc < 100) begin
         req         = directed ? ((cyc < 7) ? tbl[cyc] : '0) : NL'($urandom_range(0, 15));
         nn_req_i    = req;
         nn_output_i = directed ? 32'hA3A2_A1A0 : $urandom;
         exp_ack     = req & ~collected;
         for (int k = 0; k < NL; k++) begin
            if (exp_ack[k]) exp_res[k*DW +: DW] = nn_output_i[k*DW +: DW];
         end
         collected = collected | req;
         tick;
         chk("nn_ack", nn_ack_o, exp_ack);
         chk("result_lanes", result_o, exp_res);
         chk("done_pulse", done_o, collected == '1);
         chk("result_valid_pulse", result_valid_o, collected == '1);
         cyc++;
      end
      chk("collect_budget", collected, 4'b1111);
      nn_req_i    = '1;
      nn_output_i = $urandom;
      tick;
      nn_req_i = '0;
      chk("done_end", done_o, 0);
      chk("result_valid_end", result_valid_o, 0);
      chk("busy_end", busy_o, 0);
      chk("nn_ack_end", nn_ack_o, 0);
      chk("result_hold", result_o, exp_res);
      chk("error_end", error_o, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset_i = 1'b1; start_i = 1'b0; wt_valid_i = 1'b0; wt_data_i = '0;
      infer_ack_i = 1'b0; nn_req_i = '0; nn_output_i = '0;
      #2;
      chk_all_zero("reset");
      tick;
      reset_i = 1'b0;
      tick;
      chk("idle_after_reset", busy_o, 0);

      // Run 1: directed words, 5-cycle ack delay, lanes 2,0 then lane 1 held, then lane 3.
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
      chk("busy_load", busy_o, 1);
      load_run(0, 1'b0);
      infer_run(5);
      collect_run(1'b1);
      chk("result_directed", result_o, 32'hA3A2_A1A0);

      // Run 2: gapped valid pattern with start_i held through LOAD.
      start_i = 1'b1;
      tick;
      load_run(1, 1'b1);
      infer_run($urandom_range(1, 6));
      collect_run(1'b0);

      // Run 3: reset after two accepted words, then a full reload.
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wt_valid_i = 1'b1;
         wt_data_i  = $urandom;
         tick;
         chk("pre_reset_shift", shift_o, 1);
      end
      reset_i    = 1'b1;
      wt_valid_i = 1'b0;
      exp_res    = '0;
      last_w     = '0;
      #1;
      chk_all_zero("mid_reset");
      tick;
      reset_i = 1'b0;
      tick;
      tick;
      chk("idle_no_start", busy_o, 0);
      chk("ready_no_start", wt_ready_o, 0);
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
      load_run(2, 1'b0);
      infer_run(1);
      collect_run(1'b0);

      // Random back-to-back runs.
      for (int r = 0; r < 4; r++) begin
         start_i = 1'b1;
         tick;
         start_i = 1'b0;
         load_run(2, 1'($urandom_range(0, 1)));
         infer_run($urandom_range(1, 8));
         collect_run(1'b0);
      end

`ifdef NN_SEQ_TIMEOUT_EN
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
      load_run(2, 1'b0);
      for (int i = 0; i < TMO - 1; i++) begin
         tick;
         chk("tmo_not_yet", error_o, 0);
         chk("tmo_busy", busy_o, 1);
      end
      tick;
      chk("tmo_error", error_o, 1);
      chk("tmo_idle", busy_o, 0);
      chk("tmo_req_drop", infer_req_o, 0);
      chk("tmo_no_valid", result_valid_o, 0);
      chk("tmo_result_hold", result_o, exp_res);
      tick;
      chk("tmo_sticky", error_o, 1);
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
      chk("tmo_clear", error_o, 0);
      chk("tmo_restart", busy_o, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
